// File: rtl/sensor_proto_pkg.sv
// Shared protocol definitions for the sensor request/response link:
// command codes, frame layout, responder states and the frame checksum.
package sensor_proto_pkg;

  localparam logic [3:0] CMD_READ   = 4'h1;
  localparam logic [3:0] CMD_STATUS = 4'h2;
  localparam logic [3:0] ERR_NIBBLE = 4'hE;
  localparam int         FRAME_LEN  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Everything captured at accept time; the frame is rebuilt from this.
  typedef struct packed {
    logic [7:0]  req;
    logic [15:0] data;
    logic        valid;
    logic [7:0]  fcount;
  } snap_t;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  // Two's-complement of the byte sum, so B0+B1+B2+B3 == 0 mod 256.
  function automatic logic [7:0] checksum(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2);
    logic [7:0] s;
    s = b0 + b1 + b2;
    return ~s + 8'd1;
  endfunction

  // Response frame for an accepted request; the request address is ADDR
  // by construction, so the error byte can reuse its low nibble.
  function automatic frame_t build_frame(input snap_t s);
    frame_t f;
    f = '0;
    if (s.req[7:4] == CMD_STATUS) begin
      f[0] = s.req;
      f[1] = {7'b0, s.valid};
      f[2] = s.fcount;
    end else if (s.valid) begin
      f[0] = s.req;
      f[1] = s.data[15:8];
      f[2] = s.data[7:0];
    end else begin
      f[0] = {ERR_NIBBLE, s.req[3:0]};
    end
    f[3] = checksum(f[0], f[1], f[2]);
    return f;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared between the inter-byte gap and the per-byte tx watchdog.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sensor_responder.sv
// Decodes serial requests addressed to this sensor and streams a 4-byte
// checksummed response frame out through an external uart_tx.
module sensor_responder #(
  parameter logic [3:0] ADDR       = 4'h1,
  parameter int         GAP_CYCLES = 2,
  parameter int         TX_TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic [15:0] sensor_data,
  input  logic        sensor_valid,
  input  logic        tx_done,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [7:0]  frame_count,
  output logic        overrun,
  output logic        tx_err
);
  import sensor_proto_pkg::*;

  localparam int TMAX = (TX_TIMEOUT > GAP_CYCLES) ? TX_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  // Watchdog counts the LAUNCH cycle as its first clock.
  localparam logic [TW-1:0] WDOG_LOAD = TW'(TX_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  state_t     state;
  snap_t      snap, live_snap;
  frame_t     live_frame, snap_frame;
  logic [1:0] idx, next_idx;
  logic       accept, last_byte;
  logic       tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;

  assign live_snap  = '{req: rx_byte, data: sensor_data, valid: sensor_valid,
                        fcount: frame_count};
  assign live_frame = build_frame(live_snap);
  assign snap_frame = build_frame(snap);
  assign next_idx   = idx + 2'd1;
  assign last_byte  = (idx == 2'(FRAME_LEN - 1));
  assign accept     = (state == S_IDLE) && rx_dv && (rx_byte[3:0] == ADDR) &&
                      ((rx_byte[7:4] == CMD_READ) || (rx_byte[7:4] == CMD_STATUS));

  // Arm the shared timer: watchdog on every launch, gap after each tx_done.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = WDOG_LOAD;
    case (state)
      S_IDLE:      tmr_load = accept;
      S_WAIT_DONE: if (tx_done) begin
                     tmr_load = 1'b1;
                     tmr_val  = GAP_LOAD;
                   end
      S_GAP:       tmr_load = tmr_done && !last_byte;
      default:     tmr_load = 1'b0;
    endcase
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Frame sequencer with registered outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      snap        <= '0;
      idx         <= '0;
      tx_dv       <= 1'b0;
      tx_byte     <= 8'h00;
      busy        <= 1'b0;
      frame_count <= 8'h00;
      overrun     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_dv <= 1'b0;
      if (rx_dv && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          snap    <= live_snap;
          idx     <= '0;
          tx_byte <= live_frame[0];
          tx_dv   <= 1'b1;
          busy    <= 1'b1;
          state   <= S_LAUNCH;
        end
        S_LAUNCH: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (tx_done) begin
            state <= S_GAP;
          end else if (tmr_done) begin
            tx_err <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_GAP: if (tmr_done) begin
          if (last_byte) begin
            frame_count <= frame_count + 8'd1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            idx     <= next_idx;
            tx_byte <= snap_frame[next_idx];
            tx_dv   <= 1'b1;
            state   <= S_LAUNCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
